// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment decode table for the multiplexed
// 7-segment display driver.
package seven_seg_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int IDX_W      = $clog2(MAX_DIGITS);

  // Active-high segment patterns, bit 6 = segment a.
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high 7-segment pattern.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = seg_decode(i_nibble);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display driver: scans one digit per refresh slot with
// dead time, leading-zero suppression and optional frame-synchronous updates.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEADTIME       = 2,
  parameter bit SYNC_UPDATE    = 1'b1,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int                    CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_IDLE = ACTIVE_LOW_SEG ? ~SEG_OFF : SEG_OFF;
  localparam logic                  DP_IDLE  = ACTIVE_LOW_SEG;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = ACTIVE_LOW_AN ? '1 : '0;

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [NUM_DIGITS-1:0]   r_disp_blank;

  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [IDX_W-1:0]        r_digit_idx;
  logic                    r_frame_done;

  logic                    w_slot_end;
  logic                    w_frame_end;
  logic [3:0]              w_nibble;
  logic                    w_dp_bit;
  logic                    w_blank_bit;
  logic                    w_lz_dark;
  logic                    w_dark;
  logic                    w_dead;
  logic [6:0]              w_seg_raw;
  logic [NUM_DIGITS-1:0]   w_an_raw;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    if (SYNC_UPDATE) begin : g_sync
      logic [4*NUM_DIGITS-1:0] r_pend_val;
      logic [NUM_DIGITS-1:0]   r_pend_dp;
      logic [NUM_DIGITS-1:0]   r_pend_blank;
      logic                    r_pend;

      // A load on the frame-end edge overwrites pending after the old pending
      // data has been taken, so it waits for the following boundary.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_disp_val   <= '0;
          r_disp_dp    <= '0;
          r_disp_blank <= '0;
          r_pend_val   <= '0;
          r_pend_dp    <= '0;
          r_pend_blank <= '0;
          r_pend       <= 1'b0;
        end else begin
          if (w_frame_end && r_pend) begin
            r_disp_val   <= r_pend_val;
            r_disp_dp    <= r_pend_dp;
            r_disp_blank <= r_pend_blank;
          end
          if (load) begin
            r_pend_val   <= value;
            r_pend_dp    <= dp_in;
            r_pend_blank <= blank_in;
            r_pend       <= 1'b1;
          end else if (w_frame_end) begin
            r_pend       <= 1'b0;
          end
        end
      end
    end else begin : g_direct
      always_ff @(posedge clk) begin
        if (reset) begin
          r_disp_val   <= '0;
          r_disp_dp    <= '0;
          r_disp_blank <= '0;
        end else if (load) begin
          r_disp_val   <= value;
          r_disp_dp    <= dp_in;
          r_disp_blank <= blank_in;
        end
      end
    end
  endgenerate

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    logic upper_zero;
    upper_zero  = 1'b1;
    w_nibble    = '0;
    w_dp_bit    = 1'b0;
    w_blank_bit = 1'b0;
    w_lz_dark   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (r_disp_val[4*i +: 4] == 4'h0);
      if (r_idx == IDX_W'(i)) begin
        w_nibble    = r_disp_val[4*i +: 4];
        w_dp_bit    = r_disp_dp[i];
        w_blank_bit = r_disp_blank[i];
        w_lz_dark   = (i != 0) && upper_zero;
      end
    end
  end

  assign w_dark = w_blank_bit || (lz_suppress && w_lz_dark);
  assign w_dead = int'(r_cnt) < DEADTIME;

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_raw)
  );

  always_comb begin
    w_an_raw = '0;
    if (!w_dark && !w_dead) w_an_raw = NUM_DIGITS'(1) << r_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg        <= SEG_IDLE;
      r_dp         <= DP_IDLE;
      r_an         <= AN_IDLE;
      r_digit_idx  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= (w_dark ? SEG_OFF : w_seg_raw) ^ {7{ACTIVE_LOW_SEG}};
      r_dp         <= (w_dark ? 1'b0 : w_dp_bit) ^ ACTIVE_LOW_SEG;
      r_an         <= w_an_raw ^ {NUM_DIGITS{ACTIVE_LOW_AN}};
      r_digit_idx  <= r_idx;
      r_frame_done <= w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign digit_idx  = r_digit_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboarded bench for seven_seg_scan: one direct-update and one
// frame-synchronous instance driven from the same stimulus.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int DT = 1;

  localparam logic [6:0] DEC [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [2:0] idx;
    logic       fd;
    logic [1:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_suppress;
  logic        load;

  logic [6:0]  seg_a, seg_s;
  logic        dp_a, dp_s;
  logic [3:0]  an_a, an_s;
  logic [2:0]  idx_a, idx_s;
  logic        fd_a, fd_s;

  always #5 clk = ~clk;

  seven_seg_scan #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEADTIME(DT), .SYNC_UPDATE(1'b0),
    .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
  ) u_async (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .lz_suppress(lz_suppress), .load(load), .seg(seg_a), .dp(dp_a), .an(an_a),
    .digit_idx(idx_a), .frame_done(fd_a)
  );

  seven_seg_scan #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEADTIME(DT), .SYNC_UPDATE(1'b1),
    .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
  ) u_sync (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .lz_suppress(lz_suppress), .load(load), .seg(seg_s), .dp(dp_s), .an(an_s),
    .digit_idx(idx_s), .frame_done(fd_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: scan phase plus display state for each instance.
  int          m_cnt, m_idx;
  logic [15:0] m_val [2];
  logic [3:0]  m_dp  [2];
  logic [3:0]  m_bl  [2];
  logic [15:0] p_val;
  logic [3:0]  p_dp, p_bl;
  logic        p_pend;
  bit          sb_on = 1'b0;
  exp_t        q_a[$];
  exp_t        q_s[$];
  exp_t        last_exp;

  function automatic exp_t predict(input logic [15:0] v, input logic [3:0] dpm,
                                   input logic [3:0] bl, input int cnt, input int idx,
                                   input logic lz);
    exp_t       e;
    logic       dark;
    logic [3:0] nib;
    nib   = v[4*idx +: 4];
    dark  = bl[idx] || (lz && idx >= 1 && (v >> (4*idx)) == 16'h0);
    e.seg = dark ? 7'h7F : ~DEC[nib];
    e.dp  = dark ? 1'b1 : ~dpm[idx];
    e.an  = (dark || cnt < DT) ? 4'hF : ~(4'b0001 << idx);
    e.idx = 3'(idx);
    e.fd  = (cnt == RD - 1) && (idx == ND - 1);
    e.cnt = 2'(cnt);
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t ea, es;
    logic fe;
    if (reset) begin
      ea = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, idx: 3'd0, fd: 1'b0, cnt: 2'd0};
      es = ea;
      m_cnt <= 0;
      m_idx <= 0;
      for (int k = 0; k < 2; k++) begin
        m_val[k] <= '0;
        m_dp[k]  <= '0;
        m_bl[k]  <= '0;
      end
      p_val  <= '0;
      p_dp   <= '0;
      p_bl   <= '0;
      p_pend <= 1'b0;
      sb_on  = 1'b1;
    end else begin
      ea = predict(m_val[0], m_dp[0], m_bl[0], m_cnt, m_idx, lz_suppress);
      es = predict(m_val[1], m_dp[1], m_bl[1], m_cnt, m_idx, lz_suppress);
      fe = (m_cnt == RD - 1) && (m_idx == ND - 1);
      if (load) begin
        m_val[0] <= value;
        m_dp[0]  <= dp_in;
        m_bl[0]  <= blank_in;
      end
      if (fe && p_pend) begin
        m_val[1] <= p_val;
        m_dp[1]  <= p_dp;
        m_bl[1]  <= p_bl;
      end
      if (load) begin
        p_val  <= value;
        p_dp   <= dp_in;
        p_bl   <= blank_in;
        p_pend <= 1'b1;
      end else if (fe) begin
        p_pend <= 1'b0;
      end
      if (m_cnt == RD - 1) begin
        m_cnt <= 0;
        m_idx <= (m_idx + 1) % ND;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
    if (sb_on) begin
      q_a.push_back(ea);
      q_s.push_back(es);
      last_exp = ea;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("async.seg", seg_a, e.seg);
      check("async.dp",  dp_a,  e.dp);
      check("async.an",  an_a,  e.an);
      check("async.idx", idx_a, e.idx);
      check("async.fd",  fd_a,  e.fd);
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      check("sync.seg", seg_s, e.seg);
      check("sync.dp",  dp_s,  e.dp);
      check("sync.an",  an_s,  e.an);
      check("sync.idx", idx_s, e.idx);
      check("sync.fd",  fd_s,  e.fd);
    end
  end

  // Wait until the displayed output belongs to digit d, slot cycle c.
  task automatic wait_out(input int d, input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(int'(last_exp.idx) == d && int'(last_exp.cnt) == c) && n < 64);
    check("wait_out_phase", {last_exp.idx, last_exp.cnt}, {3'(d), 2'(c)});
  endtask

  // Wait until the scan state that the next edge samples is digit d, cycle c.
  task automatic wait_state(input int d, input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_idx == d && m_cnt == c) && n < 64);
    check("wait_state_phase", {m_idx[2:0], m_cnt[1:0]}, {3'(d), 2'(c)});
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    value    = v;
    dp_in    = d;
    blank_in = b;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         last_fd;
    int         pulses;
    logic [2:0] prev_idx;

    reset = 1'b1; value = '0; dp_in = '0; blank_in = '0; lz_suppress = 1'b0; load = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.an",  an_a,  4'hF);
    check("reset.seg", seg_a, 7'h7F);
    check("reset.dp",  dp_s,  1'b1);
    reset = 1'b0;

    // Direct update: 12AF.
    do_load(16'h12AF, 4'h0, 4'h0);
    wait_out(0, 1);
    check("d0.F.seg", seg_a, 7'b0111000);
    check("d0.F.an",  an_a,  4'b1110);
    wait_out(3, 2);
    check("d3.1.seg", seg_a, 7'b1001111);
    check("d3.1.an",  an_a,  4'b0111);
    wait_out(1, 0);
    check("dead.an",  an_a,  4'b1111);
    for (int c = 1; c < RD; c++) begin
      @(negedge clk);
      check("live.an", an_a, 4'b1101);
    end

    // Leading-zero suppression on 0030.
    lz_suppress = 1'b1;
    do_load(16'h0030, 4'h0, 4'h0);
    wait_out(3, 2);
    check("lz.d3.an",  an_a,  4'hF);
    check("lz.d3.seg", seg_a, 7'h7F);
    wait_out(2, 2);
    check("lz.d2.an",  an_a,  4'hF);
    check("lz.d2.seg", seg_a, 7'h7F);
    wait_out(1, 2);
    check("lz.d1.seg", seg_a, 7'b0000110);
    wait_out(0, 2);
    check("lz.d0.seg", seg_a, 7'b0000001);
    lz_suppress = 1'b0;
    wait_out(3, 2);
    check("nolz.d3.seg", seg_a, 7'b0000001);
    check("nolz.d3.an",  an_a,  4'b0111);
    wait_out(2, 2);
    check("nolz.d2.seg", seg_a, 7'b0000001);

    // Frame-synchronous update: last load before the boundary wins.
    wait_out(0, 1);
    do_load(16'h1111, 4'h0, 4'h0);
    do_load(16'h2222, 4'h0, 4'h0);
    wait_out(1, 2);
    check("sync.hold.d1",  seg_s, 7'b0000110);
    check("async.now.d1",  seg_a, 7'b0010010);
    wait_out(3, 2);
    check("sync.hold.d3",  seg_s, 7'b0000001);
    wait_out(0, 1);
    check("sync.new.d0",   seg_s, 7'b0010010);
    check("sync.new.an",   an_s,  4'b1110);

    // Load sampled on the frame-end edge is deferred a full frame.
    wait_state(3, 3);
    value = 16'h5555; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_out(0, 1);
    check("defer.sync.d0",  seg_s, 7'b0010010);
    check("defer.async.d0", seg_a, 7'b0100100);
    wait_out(0, 1);
    check("defer.applied",  seg_s, 7'b0100100);

    // Blank and decimal-point masks.
    do_load(16'h8888, 4'b0001, 4'b0100);
    wait_out(3, 3);
    wait_out(0, 1);
    check("mask.d0.seg", seg_s, 7'b0000000);
    check("mask.d0.dp",  dp_s,  1'b0);
    check("mask.d0.an",  an_s,  4'b1110);
    wait_out(1, 1);
    check("mask.d1.dp",  dp_s,  1'b1);
    wait_out(2, 1);
    check("mask.d2.an",  an_s,  4'hF);
    check("mask.d2.seg", seg_s, 7'h7F);
    check("mask.d2.dp",  dp_s,  1'b1);
    wait_out(3, 1);
    check("mask.d3.dp",  dp_s,  1'b1);
    check("mask.d3.an",  an_s,  4'b0111);

    // Mid-frame reset with a competing load.
    wait_state(2, 2);
    reset = 1'b1; load = 1'b1; value = 16'hFFFF;
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    check("rst.an",  an_a,  4'hF);
    check("rst.seg", seg_s, 7'h7F);
    check("rst.dp",  dp_a,  1'b1);
    check("rst.idx", idx_s, 3'd0);
    check("rst.fd",  fd_a,  1'b0);
    @(negedge clk);
    check("resume.idx", idx_a, 3'd0);
    check("resume.an",  an_a,  4'hF);
    @(negedge clk);
    check("resume.a.seg", seg_a, 7'b0000001);
    check("resume.s.seg", seg_s, 7'b0000001);
    check("resume.an1",   an_a,  4'b1110);

    // Three frames of free-running scan.
    last_fd  = -1;
    pulses   = 0;
    prev_idx = idx_a;
    for (int i = 0; i < 3 * ND * RD; i++) begin
      @(negedge clk);
      check("an_onehot.a", $countones(~an_a) <= 1, 1'b1);
      check("an_onehot.s", $countones(~an_s) <= 1, 1'b1);
      if (idx_a != prev_idx) check("idx_seq", idx_a, 3'((int'(prev_idx) + 1) % ND));
      prev_idx = idx_a;
      if (fd_a) begin
        if (last_fd >= 0) check("fd_gap", i - last_fd, ND * RD);
        last_fd = i;
        pulses++;
      end
    end
    check("fd_count", pulses, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
